// File: rtl/mem_arbiter_if.sv
// Bundle of the I/D requester ports, the shared memory port and the busy flag.
// slave is the arbiter's view; master is the view of the fetch/LSU + memory side.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            i_req_i;
    logic [AW-1:0]   i_addr_i;
    logic            i_gnt_o;
    logic            i_rvalid_o;
    logic [DW-1:0]   i_rdata_o;
    logic            i_err_o;

    logic            d_req_i;
    logic            d_we_i;
    logic [DW/8-1:0] d_be_i;
    logic [AW-1:0]   d_addr_i;
    logic [DW-1:0]   d_wdata_i;
    logic            d_gnt_o;
    logic            d_rvalid_o;
    logic [DW-1:0]   d_rdata_o;
    logic            d_err_o;

    logic            m_req_o;
    logic            m_we_o;
    logic [DW/8-1:0] m_be_o;
    logic [AW-1:0]   m_addr_o;
    logic [DW-1:0]   m_wdata_o;
    logic            m_gnt_i;
    logic            m_rvalid_i;
    logic [DW-1:0]   m_rdata_i;
    logic            m_err_i;

    logic            busy_o;

    modport slave (
        input  i_req_i, i_addr_i,
        output i_gnt_o, i_rvalid_o, i_rdata_o, i_err_o,
        input  d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
        output d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
        output m_req_o, m_we_o, m_be_o, m_addr_o, m_wdata_o,
        input  m_gnt_i, m_rvalid_i, m_rdata_i, m_err_i,
        output busy_o
    );

    modport master (
        output i_req_i, i_addr_i,
        input  i_gnt_o, i_rvalid_o, i_rdata_o, i_err_o,
        output d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
        input  d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
        input  m_req_o, m_we_o, m_be_o, m_addr_o, m_wdata_o,
        output m_gnt_i, m_rvalid_i, m_rdata_i, m_err_i,
        input  busy_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (I) and
// load/store (D); one outstanding transaction, response timeout turns into an error.

module mem_arbiter_rsp #(
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          fire,
    input  logic          err,
    input  logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic [DW-1:0] rdata_q,
    output logic          err_q
);
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rvalid  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            rvalid <= fire;
            if (fire) begin
                rdata_q <= rdata;
                err_q   <= err;
            end
        end
    end
endmodule

module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input logic         clk_i,
    input logic         rstn_i,
    mem_arbiter_if.slave bus
);
    localparam int BW = DW / 8;
    localparam int NP = 2;
    localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef struct packed {
        logic          we;
        logic [BW-1:0] be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    logic [1:0]    state_q;
    logic          last_q;
    logic          owner_q;
    logic [TW-1:0] timer_q;
    logic          m_req_q;
    cmd_t          cmd_q;
    cmd_t          cmd_new;

    logic          gnt_i;
    logic          gnt_d;
    logic          resp_hit;
    logic          to_hit;
    logic          rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [NP-1:0] fire;

    logic [NP-1:0]         rsp_vld;
    logic [NP-1:0]         rsp_errq;
    logic [NP-1:0][DW-1:0] rsp_rdq;

    // Tie goes to the port that did not win last; grants are gated by reset so
    // nothing leaks out while rstn_i is low.
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (rstn_i && state_q == S_IDLE) begin
            if (bus.d_req_i && (!bus.i_req_i || last_q == PORT_I))
                gnt_d = 1'b1;
            else if (bus.i_req_i)
                gnt_i = 1'b1;
        end
    end

    always_comb begin
        cmd_new = '0;
        if (gnt_d) begin
            cmd_new.we    = bus.d_we_i;
            cmd_new.be    = bus.d_be_i;
            cmd_new.addr  = bus.d_addr_i;
            cmd_new.wdata = bus.d_wdata_i;
        end else begin
            cmd_new.we    = 1'b0;
            cmd_new.be    = '1;
            cmd_new.addr  = bus.i_addr_i;
            cmd_new.wdata = '0;
        end
    end

    // A response arriving in the same cycle as the timeout wins.
    always_comb begin
        resp_hit  = (state_q == S_RESP) && bus.m_rvalid_i;
        to_hit    = TO_EN && (state_q == S_RESP) && !bus.m_rvalid_i && (timer_q == TO_LAST);
        rsp_err   = resp_hit ? bus.m_err_i : 1'b1;
        rsp_rdata = resp_hit ? bus.m_rdata_i : '0;
        fire      = '0;
        if (resp_hit || to_hit)
            fire[owner_q] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            last_q  <= PORT_I;
            owner_q <= PORT_I;
            timer_q <= '0;
            m_req_q <= 1'b0;
            cmd_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_i || gnt_d) begin
                        state_q <= S_REQ;
                        m_req_q <= 1'b1;
                        owner_q <= gnt_d ? PORT_D : PORT_I;
                        last_q  <= gnt_d ? PORT_D : PORT_I;
                        cmd_q   <= cmd_new;
                    end
                end
                S_REQ: begin
                    if (bus.m_gnt_i) begin
                        m_req_q <= 1'b0;
                        timer_q <= '0;
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_hit)
                        state_q <= S_IDLE;
                    else if (to_hit)
                        state_q <= S_DRAIN;
                    else if (timer_q != '1)
                        timer_q <= timer_q + 1'b1;
                end
                S_DRAIN: begin
                    if (bus.m_rvalid_i)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    for (genvar p = 0; p < NP; p++) begin : g_rsp
        mem_arbiter_rsp #(.DW(DW)) u_rsp (
            .clk_i   (clk_i),
            .rstn_i  (rstn_i),
            .fire    (fire[p]),
            .err     (rsp_err),
            .rdata   (rsp_rdata),
            .rvalid  (rsp_vld[p]),
            .rdata_q (rsp_rdq[p]),
            .err_q   (rsp_errq[p])
        );
    end

    assign bus.i_gnt_o    = gnt_i;
    assign bus.d_gnt_o    = gnt_d;
    assign bus.i_rvalid_o = rsp_vld[PORT_I];
    assign bus.i_rdata_o  = rsp_rdq[PORT_I];
    assign bus.i_err_o    = rsp_errq[PORT_I];
    assign bus.d_rvalid_o = rsp_vld[PORT_D];
    assign bus.d_rdata_o  = rsp_rdq[PORT_D];
    assign bus.d_err_o    = rsp_errq[PORT_D];

    assign bus.m_req_o   = m_req_q;
    assign bus.m_we_o    = cmd_q.we;
    assign bus.m_be_o    = cmd_q.be;
    assign bus.m_addr_o  = cmd_q.addr;
    assign bus.m_wdata_o = cmd_q.wdata;
    assign bus.busy_o    = (state_q != S_IDLE);
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares the single memory port between the CPU's instruction-fetch path (I) and its load/store path (D).
- Round-robin arbitration when both request; one transaction outstanding at a time.
- Sits between the fetch/LSU logic and the memory (instruction/data RAM) in `cpu`.
- Routes each response to its owner, and converts a missing response into an error after a programmable timeout.

## Interface
- `AW`, 32, address width.
- `DW`, 32, data width (multiple of 8).
- `TIMEOUT`, 255, max cycles in RESP before error; 0 = timeout disabled.

Ports:
- `clk_i`  in  1  clock, all logic on rising edge.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `i_req_i`  in  1  instruction read request; held with `i_addr_i` until `i_gnt_o`.
- `i_addr_i`  in  AW  fetch address.
- `i_gnt_o`  out  1  request accepted (combinational, 1 cycle).
- `i_rvalid_o`  out  1  response pulse (registered).
- `i_rdata_o`  out  DW  response data, valid with `i_rvalid_o`.
- `i_err_o`  out  1  response error, valid with `i_rvalid_o`.
- `d_req_i`, `d_we_i`, `d_be_i[DW/8]`, `d_addr_i[AW]`, `d_wdata_i[DW]`  in  data request; held until `d_gnt_o`.
- `d_gnt_o`, `d_rvalid_o`, `d_rdata_o[DW]`, `d_err_o`  out  same meaning as the I port.
- `m_req_o`, `m_we_o`, `m_be_o`, `m_addr_o`, `m_wdata_o`  out  memory command, all registered.
- `m_gnt_i`  in  1  memory accepts the command this cycle.
- `m_rvalid_i`, `m_rdata_i[DW]`, `m_err_i`  in  memory response, 1-cycle pulse.
- `busy_o`  out  1  state != IDLE (feeds sleep logic).

## Operation
- States: IDLE, REQ, RESP, DRAIN.
- IDLE, arbitration:
  - `winner` = D if only `d_req_i`; I if only `i_req_i`.
  - If both: the port not in `last_q`.
  - `last_q` resets to I, so D wins the first tie.
- IDLE, on grant:
  - Assert the winner's `x_gnt_o`.
  - Latch the command: addr; for D also we/be/wdata; for I, we=0, be=all ones, wdata=0.
  - Latch `owner`, set `last_q` = winner, go to REQ.
- Never both gnt in one cycle; no gnt outside IDLE.
- REQ:
  - `m_req_o`=1 with the latched command held stable.
  - On `m_gnt_i`: clear `timer`, go to RESP.
  - No timeout in REQ.
- RESP: `timer` increments each cycle.
  - On `m_rvalid_i`:
    - Next cycle: `owner`'s `x_rvalid_o`=1, `x_rdata_o`=`m_rdata_i`, `x_err_o`=`m_err_i`.
    - Go to IDLE.
  - Else if `TIMEOUT`!=0 and `timer`==`TIMEOUT`-1:
    - Next cycle: `owner`'s `x_rvalid_o`=1, `x_err_o`=1, `x_rdata_o`=0.
    - Go to DRAIN.
- DRAIN:
  - Wait for the late `m_rvalid_i`, discard it (no output pulse), go to IDLE.
  - No timeout here; `busy_o` stays 1.
- Stores also get exactly one response; `d_rdata_o` is whatever memory returns.
- `m_rvalid_i` in IDLE or REQ is a protocol violation and is ignored.
- `timer` is an 8-bit saturating counter, sized ≥ clog2(`TIMEOUT`+1).

## Timing
- Reset values:
  - All outputs 0: `*_gnt_o`, `*_rvalid_o`, `*_rdata_o`, `*_err_o`, `m_*`, `busy_o`.
  - State IDLE, `last_q`=I, `timer`=0.
- Reset mid-transaction:
  - Immediate return to IDLE.
  - No response delivered; `m_req_o` drops asynchronously.
- Best-case sequence:
  - Cycle 0: req + gnt.
  - Cycle 1: `m_req_o` with `m_gnt_i`.
  - Cycle 2: `m_rvalid_i`.
  - Cycle 3: `x_rvalid_o`, state IDLE, next gnt possible.
  - Throughput: 1 transaction / 3 cycles.
- `m_req_o` stays high until `m_gnt_i`; the command never changes while `m_req_o`=1.
- `x_rvalid_o` is high exactly one cycle per granted request; responses stay in grant order.
- Requester changing `x_req_i` before gnt: only the value sampled in the grant cycle counts.
- Timeout pulse is exactly `TIMEOUT` cycles after entering RESP; a coincident `m_rvalid_i` takes precedence (normal response).

## Test plan
- Single I read: `i_req_i`, addr 0x100, `m_gnt_i` immediate, `m_rdata_i`=0xDEADBEEF 1 cycle later.
  - Expect `i_gnt_o` cycle 0, `m_addr_o`=0x100/`m_we_o`=0 cycle 1, `i_rvalid_o`/`i_rdata_o`=0xDEADBEEF cycle 3, `d_rvalid_o` never.
- Contention: I and D requesting continuously from reset.
  - Expect grants D,I,D,I…; `m_we_o`/`m_be_o`/`m_wdata_o` match the D store (be=4'b0011, wdata=0x1234); each port gets one response per grant.
- Memory backpressure: hold `m_gnt_i`=0 for 5 cycles.
  - Expect `m_req_o`=1 with a constant command for 6 cycles, no new grants, `busy_o`=1.
- Timeout with `TIMEOUT`=4: no `m_rvalid_i`.
  - Expect `d_rvalid_o`=1, `d_err_o`=1, `d_rdata_o`=0 at cycle RESP+4.
  - Late `m_rvalid_i` then dropped, state IDLE next cycle, next I read correct.
- Error pass-through: `m_err_i`=1 with `m_rvalid_i`.
  - Expect `i_err_o`=1 on the I response.
- Reset asserted in RESP.
  - Expect all outputs 0 immediately, no `x_rvalid_o`.
  - After release, first tie goes to D.
